// File: rtl/add16_resp_checker.sv
// Response checker for the 16-bit adder: recomputes each sum, compares it against
// the adder's {cout,s}, keeps saturating statistics and captures the first failing vector.
module add16_resp_checker #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned CNT_W       = 16,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] s,
   input  logic             cout,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             err_flag,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic             fail_cin,
   output logic [WIDTH-1:0] fail_s,
   output logic             fail_cout,
   output logic [CNT_W-1:0] fail_idx
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t state, state_nxt;

   logic             s1_v, s1_cin, s1_cout;
   logic [WIDTH-1:0] s1_a, s1_b, s1_s;
   logic [WIDTH:0]   s1_exp;

   logic             s2_v, s2_pass, s2_cin, s2_cout;
   logic [WIDTH-1:0] s2_a, s2_b, s2_s;

   logic accept, report;

   assign accept = in_valid && (state == RUN);
   // Anything reaching stage 2 while halted is dropped without a strobe or count.
   assign report = s2_v && (state != HALT);

   assign busy   = (state == RUN);
   assign halted = (state == HALT);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (en) state_nxt = RUN;
         RUN: begin
            if (!en) state_nxt = IDLE;
            if (STOP_ON_ERR && s2_v && !s2_pass) state_nxt = HALT;
         end
         HALT: state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state     <= IDLE;
         s1_v      <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_cin    <= 1'b0;
         s1_s      <= '0;
         s1_cout   <= 1'b0;
         s1_exp    <= '0;
         s2_v      <= 1'b0;
         s2_pass   <= 1'b0;
         s2_a      <= '0;
         s2_b      <= '0;
         s2_cin    <= 1'b0;
         s2_s      <= '0;
         s2_cout   <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         err_flag  <= 1'b0;
         vec_cnt   <= '0;
         err_cnt   <= '0;
         fail_a    <= '0;
         fail_b    <= '0;
         fail_cin  <= 1'b0;
         fail_s    <= '0;
         fail_cout <= 1'b0;
         fail_idx  <= '0;
      end else begin
         state <= state_nxt;

         s1_v <= accept;
         if (accept) begin
            s1_a    <= a;
            s1_b    <= b;
            s1_cin  <= cin;
            s1_s    <= s;
            s1_cout <= cout;
            s1_exp  <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         end

         s2_v <= s1_v;
         if (s1_v) begin
            s2_pass <= ({s1_cout, s1_s} == s1_exp);
            s2_a    <= s1_a;
            s2_b    <= s1_b;
            s2_cin  <= s1_cin;
            s2_s    <= s1_s;
            s2_cout <= s1_cout;
         end

         chk_valid <= report;
         chk_pass  <= report && s2_pass;
         if (report) begin
            if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_W'(1);
            if (!s2_pass) begin
               if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
               err_flag <= 1'b1;
               if (!err_flag) begin
                  fail_a    <= s2_a;
                  fail_b    <= s2_b;
                  fail_cin  <= s2_cin;
                  fail_s    <= s2_s;
                  fail_cout <= s2_cout;
                  fail_idx  <= vec_cnt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_add16_resp_checker.sv
// Scoreboard bench for add16_resp_checker: default, stop-on-error and 4-bit-counter instances
// share one stimulus stream.
module tb_add16_resp_checker;

   logic        clk = 1'b0;
   logic        rst, en, clr, in_valid, cin, cout;
   logic [15:0] a, b, s;

   logic        d_cv, d_cp, d_ef, d_busy, d_halt, d_fcin, d_fcout;
   logic [15:0] d_vc, d_ec, d_fa, d_fb, d_fs, d_fi;

   logic        t_cv, t_cp, t_ef, t_busy, t_halt, t_fcin, t_fcout;
   logic [15:0] t_vc, t_ec, t_fa, t_fb, t_fs, t_fi;

   logic        m_cv, m_cp, m_ef, m_busy, m_halt, m_fcin, m_fcout;
   logic [3:0]  m_vc, m_ec, m_fi;
   logic [15:0] m_fa, m_fb, m_fs;

   int n_chk = 0;
   int n_pass = 0;
   int stop_strobes = 0;
   bit exp_q[$];

   logic [15:0] v3_a, v3_b, v3_s;
   logic        v3_cin, v3_cout;

   always #5 clk = ~clk;

   add16_resp_checker u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
      .chk_valid(d_cv), .chk_pass(d_cp), .err_flag(d_ef), .busy(d_busy), .halted(d_halt),
      .vec_cnt(d_vc), .err_cnt(d_ec), .fail_a(d_fa), .fail_b(d_fb), .fail_cin(d_fcin),
      .fail_s(d_fs), .fail_cout(d_fcout), .fail_idx(d_fi));

   add16_resp_checker #(.STOP_ON_ERR(1'b1)) u_stop (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
      .chk_valid(t_cv), .chk_pass(t_cp), .err_flag(t_ef), .busy(t_busy), .halted(t_halt),
      .vec_cnt(t_vc), .err_cnt(t_ec), .fail_a(t_fa), .fail_b(t_fb), .fail_cin(t_fcin),
      .fail_s(t_fs), .fail_cout(t_fcout), .fail_idx(t_fi));

   add16_resp_checker #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
      .chk_valid(m_cv), .chk_pass(m_cp), .err_flag(m_ef), .busy(m_busy), .halted(m_halt),
      .vec_cnt(m_vc), .err_cnt(m_ec), .fail_a(m_fa), .fail_b(m_fb), .fail_cin(m_fcin),
      .fail_s(m_fs), .fail_cout(m_fcout), .fail_idx(m_fi));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      else n_pass++;
   endtask

   // Scoreboard: compare every strobe of the default instance against the queued expectation.
   always @(posedge clk) begin
      #1;
      if (d_cv) begin
         if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else check("chk_pass", {31'd0, d_cp}, {31'd0, exp_q.pop_front()});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst) stop_strobes = 0;
      else if (t_cv) stop_strobes++;
   end

   task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                       input logic [15:0] vs, input logic vcout);
      logic [16:0] sum;
      a = va; b = vb; cin = vcin; s = vs; cout = vcout; in_valid = 1'b1;
      sum = {1'b0, va} + {1'b0, vb} + {16'd0, vcin};
      exp_q.push_back(sum == {vcout, vs});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; clr = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      logic [16:0] sum;
      logic [15:0] ra, rb;
      logic        rc;
      rst = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
      @(negedge clk);
      do_reset();

      check("rst_chk_valid", {31'd0, d_cv}, 32'd0);
      check("rst_chk_pass", {31'd0, d_cp}, 32'd0);
      check("rst_err_flag", {31'd0, d_ef}, 32'd0);
      check("rst_busy", {31'd0, d_busy}, 32'd0);
      check("rst_halted", {31'd0, d_halt}, 32'd0);
      check("rst_vec_cnt", {16'd0, d_vc}, 32'd0);
      check("rst_err_cnt", {16'd0, d_ec}, 32'd0);
      check("rst_fail_idx", {16'd0, d_fi}, 32'd0);

      // In IDLE, beats are not accepted.
      send(16'h0001, 16'h0001, 1'b0, 16'h0005, 1'b0);
      void'(exp_q.pop_back());
      idle(3);
      check("idle_ignored_vec_cnt", {16'd0, d_vc}, 32'd0);

      en = 1'b1;
      idle(1);
      check("run_busy", {31'd0, d_busy}, 32'd1);

      send(16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0);
      idle(1);
      check("latency_no_strobe_yet", {31'd0, d_cv}, 32'd0);
      idle(2);
      check("basic_vec_cnt", {16'd0, d_vc}, 32'd1);
      check("basic_err_cnt", {16'd0, d_ec}, 32'd0);
      check("basic_err_flag", {31'd0, d_ef}, 32'd0);

      do_reset();
      idle(1);
      send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
      idle(4);
      check("carry_vec_cnt", {16'd0, d_vc}, 32'd2);
      check("carry_err_cnt", {16'd0, d_ec}, 32'd1);
      check("carry_err_flag", {31'd0, d_ef}, 32'd1);
      check("carry_fail_idx", {16'd0, d_fi}, 32'd1);
      check("carry_fail_a", {16'd0, d_fa}, 32'h0000FFFF);
      check("carry_fail_s", {16'd0, d_fs}, 32'd0);
      check("carry_fail_cout", {31'd0, d_fcout}, 32'd0);

      do_reset();
      idle(1);
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         if (i == 3 || i == 7) sum[0] = ~sum[0];
         if (i == 3) begin
            v3_a = ra; v3_b = rb; v3_cin = rc; v3_s = sum[15:0]; v3_cout = sum[16];
         end
         send(ra, rb, rc, sum[15:0], sum[16]);
      end
      idle(4);
      check("cap_vec_cnt", {16'd0, d_vc}, 32'd10);
      check("cap_err_cnt", {16'd0, d_ec}, 32'd2);
      check("cap_fail_idx", {16'd0, d_fi}, 32'd3);
      check("cap_fail_a", {16'd0, d_fa}, {16'd0, v3_a});
      check("cap_fail_b", {16'd0, d_fb}, {16'd0, v3_b});
      check("cap_fail_cin", {31'd0, d_fcin}, {31'd0, v3_cin});
      check("cap_fail_s", {16'd0, d_fs}, {16'd0, v3_s});
      check("cap_fail_cout", {31'd0, d_fcout}, {31'd0, v3_cout});

      do_reset();
      idle(1);
      for (int i = 0; i < 6; i++)
         send(16'(i * 16'h0101), 16'h0010, 1'b0, 16'(i * 16'h0101 + 16'h0010 + (i == 2 ? 1 : 0)), 1'b0);
      idle(4);
      check("stop_halted", {31'd0, t_halt}, 32'd1);
      check("stop_busy", {31'd0, t_busy}, 32'd0);
      check("stop_vec_cnt", {16'd0, t_vc}, 32'd3);
      check("stop_err_cnt", {16'd0, t_ec}, 32'd1);
      check("stop_fail_idx", {16'd0, t_fi}, 32'd2);
      check("stop_strobes", stop_strobes, 32'd3);
      check("nostop_vec_cnt", {16'd0, d_vc}, 32'd6);
      send(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);
      send(16'h0002, 16'h0003, 1'b0, 16'h0007, 1'b0);
      idle(4);
      check("halt_ignores_vec_cnt", {16'd0, t_vc}, 32'd3);
      check("halt_ignores_strobes", stop_strobes, 32'd3);
      en = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_q.delete();
      check("clr_halted", {31'd0, t_halt}, 32'd0);
      check("clr_busy", {31'd0, t_busy}, 32'd0);
      check("clr_vec_cnt", {16'd0, t_vc}, 32'd0);
      check("clr_err_cnt", {16'd0, t_ec}, 32'd0);
      check("clr_err_flag", {31'd0, t_ef}, 32'd0);
      check("clr_fail_a", {16'd0, t_fa}, 32'd0);
      check("clr_fail_idx", {16'd0, t_fi}, 32'd0);
      idle(2);
      check("clr_stays_idle", {31'd0, t_busy}, 32'd0);

      do_reset();
      en = 1'b1;
      idle(1);
      for (int i = 0; i < 20; i++) send(16'(i), 16'h0001, 1'b0, 16'(i), 1'b0);
      idle(4);
      check("sat_vec_cnt", {28'd0, m_vc}, 32'd15);
      check("sat_err_cnt", {28'd0, m_ec}, 32'd15);
      check("sat_fail_idx", {28'd0, m_fi}, 32'd0);
      check("sat_wide_err_cnt", {16'd0, d_ec}, 32'd20);

      send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_strobe", {31'd0, d_cv}, 32'd0);
      end
      check("midrst_vec_cnt", {16'd0, d_vc}, 32'd0);
      check("midrst_err_cnt", {16'd0, d_ec}, 32'd0);

      send(16'h0100, 16'h0200, 1'b0, 16'h0000, 1'b0);
      idle(1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_q.delete();
      check("clrcmp_err_flag", {31'd0, d_ef}, 32'd0);
      check("clrcmp_err_cnt", {16'd0, d_ec}, 32'd0);
      check("clrcmp_chk_valid", {31'd0, d_cv}, 32'd0);
      idle(3);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/add16_resp_checker.md
Name: add16_resp_checker

Overview:
- Response-side checker for the 16-bit adder. It consumes the operand/result vectors that a stimulus source and the add16 instance produce each cycle.
- It recomputes the expected 17-bit sum, compares it against the sum and carry the adder returned, and keeps pass/error statistics.
- On the first mismatch it captures the full failing vector so that hardware self-test or a bench can read it back.
- It sits alongside add16 and observes it; it never drives add16's inputs.

Parameters:
- WIDTH, 16, operand and sum width.
- CNT_W, 16, width of the vector and error counters, which saturate at 2^CNT_W-1.
- STOP_ON_ERR, 0. When 1, the first mismatch halts checking until clr is asserted. When 0, checking continues after a mismatch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arms the checker; sampled in IDLE.
- clr  in  1  synchronous clear of counters, flags and capture; returns the checker to IDLE.
- in_valid  in  1  the current a/b/cin/s/cout beat is valid.
- a  in  WIDTH  operand A presented to the adder.
- b  in  WIDTH  operand B presented to the adder.
- cin  in  1  carry-in presented to the adder.
- s  in  WIDTH  sum returned by the adder.
- cout  in  1  carry-out returned by the adder.
- chk_valid  out  1  one-cycle strobe: a compare result is available.
- chk_pass  out  1  result of that compare, valid only while chk_valid=1.
- err_flag  out  1  sticky: at least one mismatch has occurred.
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.
- vec_cnt  out  CNT_W  number of vectors checked.
- err_cnt  out  CNT_W  number of mismatches.
- fail_a  out  WIDTH  A of the first failing vector.
- fail_b  out  WIDTH  B of the first failing vector.
- fail_cin  out  1  cin of the first failing vector.
- fail_s  out  WIDTH  s of the first failing vector.
- fail_cout  out  1  cout of the first failing vector.
- fail_idx  out  CNT_W  value of vec_cnt at the first failing vector, 0-based.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, which is sampled on the rising edge of clk.
- Reset: every output is 0, both pipeline valid bits are 0, and the state is IDLE.
- States:
  - IDLE: in_valid is ignored. If en=1, go to RUN on the next edge.
  - RUN: checks vectors. If STOP_ON_ERR=1 and a stage-2 compare fails, go to HALT.
  - HALT: in_valid is ignored and the pipeline drains without producing further chk_valid. Leave HALT only through clr or rst.
  - en=0 while in RUN returns the checker to IDLE on the next edge. Beats already in the pipeline still complete.
- Pipeline, 2 stages:
  - Stage 1: if in_valid=1 and the state is RUN, register a, b, cin, s and cout, and compute exp = {1'b0,a} + {1'b0,b} + cin, which is WIDTH+1 bits wide.
  - Stage 2: pass = ({cout,s} == exp). Assert chk_valid and drive chk_pass.
  - Latency: a beat accepted at edge t produces chk_valid at edge t+2. Throughput is one vector per cycle.
- Statistics update at stage 2:
  - vec_cnt increments by 1 and saturates at all-ones.
  - On a mismatch, err_cnt increments by 1 and saturates at all-ones, and err_flag is set.
  - Saturation never wraps to 0.
- Capture: on the first mismatch after a reset or clr, load fail_a, fail_b, fail_cin, fail_s, fail_cout and fail_idx. fail_idx takes the pre-increment value of vec_cnt. Later mismatches do not overwrite the capture.
- STOP_ON_ERR=1: the vector that follows a failing vector may already be in stage 1. It is discarded: no chk_valid and no counter update.
- clr:
  - Clears counters, err_flag, the capture registers and both pipeline stages, and sets the state to IDLE.
  - clr has priority over any simultaneous in_valid or compare.
  - rst has priority over clr.
- Mid-operation reset: rst during RUN flushes the pipeline. No chk_valid appears on the following cycles.
- Arithmetic: the expected sum is always computed at WIDTH+1 bits, so the carry-out bit equals bit WIDTH of exp. Operands are treated as unsigned.

Test Plan:
- Basic pass: rst, then en=1. Apply a=16'h1234, b=16'h0001, cin=1, s=16'h1236, cout=0 with in_valid=1 for one cycle → chk_valid=1 and chk_pass=1 two cycles later; vec_cnt=1, err_cnt=0, err_flag=0.
- Carry boundary: a=16'hFFFF, b=16'h0000, cin=1, s=16'h0000, cout=1 → pass. Repeat with cout=0 → fail; err_cnt=1, fail_idx=1, fail_s=16'h0000, fail_cout=0.
- First-error capture: 10 back-to-back random correct vectors, with vectors 3 and 7 (0-based) corrupted in s bit 0 → err_cnt=2, fail_idx=3, capture equals vector 3, vec_cnt=10.
- STOP_ON_ERR=1: a stream whose vector 2 fails → halted=1; vec_cnt=3; vector 3 produces no chk_valid; further in_valid is ignored. Then clr → all outputs 0 and state IDLE.
- Saturation with CNT_W=4: 20 failing vectors → vec_cnt=15, err_cnt=15, fail_idx=0.
- Reset mid-stream: assert rst on the cycle after a valid beat → chk_valid stays 0 and all counters are 0. Assert clr simultaneously with a failing stage-2 compare → err_flag=0 and err_cnt=0.
